// File: rtl/mem_pkg.sv
// Shared types and constants for the external 16-bit SRAM port and its arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_BEAT = 3'd1,
        WR_BEAT = 3'd2,
        RMW_RD  = 3'd3,
        RMW_WR  = 3'd4,
        WAIT    = 3'd5,
        RESP    = 3'd6
    } arb_state_e;

    localparam logic [63:0] SRAM_BASE   = 64'h8000_0000;
    localparam int unsigned SRAM_HWORDS = 2**19;

    // Halfword beats needed for a plain (non-RMW) access of the given size.
    function automatic logic [2:0] beat_count(input mem_size_e sz);
        case (sz)
            SZ_W:    return 3'd2;
            SZ_D:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request arbiter: round-robin on the last grant, or fixed priority to port 0.
module rr_arbiter2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // Port that won the previous grant; reset value lets port 0 win first.
    logic last_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (RR_EN && !last_q) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one 16-bit external SRAM between two 64-bit requesters, splitting each
// access into halfword beats and doing read-modify-write for byte stores.
module sram_bus_arbiter
    import mem_pkg::*;
#(
    parameter bit          RR_EN       = 1'b1,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      p_req,
    input  logic [1:0]      p_we,
    input  logic [1:0][1:0] p_size,
    input  logic [1:0][63:0] p_addr,
    input  logic [1:0][63:0] p_wdata,
    output logic [1:0]      p_ack,
    output logic [1:0]      p_err,
    output logic [1:0][63:0] p_rdata,
    output logic [18:0]     sram_addr,
    inout  wire  [15:0]     sram_dq,
    output logic            sram_we
);

    arb_state_e  state_q, state_d, beat_st_q, after_beat;
    logic [1:0]  gnt;
    logic        grant, g_port, g_err;
    logic [63:0] g_addr, g_off;
    mem_size_e   g_size, size_q;
    logic        port_q, err_q, byte_sel_q;
    logic [1:0]  beat_q;
    logic [2:0]  wait_q;
    logic [63:0] wdata_q, rdata_q;
    logic [15:0] rmw_q, dq_out;
    logic        in_beat, beat_done, last_beat;

    function automatic logic [2:0] align_mask(input mem_size_e sz);
        return 3'((4'd1 << sz) - 4'd1);
    endfunction

    rr_arbiter2 #(.RR_EN(RR_EN)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (p_req),
        .update (grant),
        .gnt    (gnt)
    );

    assign grant  = (state_q == IDLE) && (gnt != 2'b00);
    assign g_port = gnt[1];
    assign g_addr = p_addr[g_port];
    assign g_size = mem_size_e'(p_size[g_port]);
    assign g_off  = g_addr - SRAM_BASE;
    assign g_err  = (g_addr < SRAM_BASE) || (g_off >= 64'(2 * SRAM_HWORDS)) ||
                    ((g_addr[2:0] & align_mask(g_size)) != 3'd0);

    // A beat spans its strobe cycle plus WAIT_CYCLES idle cycles; it ends on the last of them.
    assign in_beat   = state_q inside {RD_BEAT, WR_BEAT, RMW_RD, RMW_WR};
    assign beat_done = (in_beat && (WAIT_CYCLES == 0)) || ((state_q == WAIT) && (wait_q == 3'd0));
    assign last_beat = ({1'b0, beat_q} == (beat_count(size_q) - 3'd1));

    always_comb begin
        after_beat = RESP;
        case (beat_st_q)
            RMW_RD:           after_beat = RMW_WR;
            RMW_WR:           after_beat = RESP;
            RD_BEAT, WR_BEAT: after_beat = last_beat ? RESP : beat_st_q;
            default:          after_beat = RESP;
        endcase

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    if (g_err)                 state_d = RESP;
                    else if (!p_we[g_port])    state_d = RD_BEAT;
                    else if (g_size == SZ_B)   state_d = RMW_RD;
                    else                       state_d = WR_BEAT;
                end
            end
            RD_BEAT, WR_BEAT, RMW_RD, RMW_WR, WAIT: begin
                if (in_beat && (WAIT_CYCLES != 0)) state_d = WAIT;
                else if (beat_done)                state_d = after_beat;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_st_q <= IDLE;
            wait_q    <= 3'd0;
            beat_q    <= 2'd0;
            port_q    <= 1'b0;
            err_q     <= 1'b0;
            sram_addr <= 19'd0;
            rdata_q   <= 64'd0;
        end else begin
            if (grant) begin
                port_q  <= g_port;
                err_q   <= g_err;
                beat_q  <= 2'd0;
                rdata_q <= 64'd0;
                if (!g_err) sram_addr <= g_off[19:1];
            end
            if (state_d inside {RD_BEAT, WR_BEAT, RMW_RD, RMW_WR}) beat_st_q <= state_d;
            if (in_beat)                wait_q <= 3'(WAIT_CYCLES - 1);
            else if (state_q == WAIT)   wait_q <= wait_q - 3'd1;
            if (beat_done) begin
                if (beat_st_q == RD_BEAT) begin
                    if (size_q == SZ_B) rdata_q <= {56'd0, byte_sel_q ? sram_dq[15:8] : sram_dq[7:0]};
                    else                rdata_q[{beat_q, 4'd0} +: 16] <= sram_dq;
                end
                if ((beat_st_q == RD_BEAT || beat_st_q == WR_BEAT) && !last_beat) begin
                    beat_q    <= beat_q + 2'd1;
                    sram_addr <= sram_addr + 19'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            size_q     <= g_size;
            byte_sel_q <= g_addr[0];
            wdata_q    <= p_wdata[g_port];
        end
        if (beat_done && (beat_st_q == RMW_RD)) rmw_q <= sram_dq;
    end

    // Byte store merges the new byte into the halfword fetched by the RMW read beat.
    assign dq_out  = (state_q == RMW_WR)
                   ? (byte_sel_q ? {wdata_q[7:0], rmw_q[7:0]} : {rmw_q[15:8], wdata_q[7:0]})
                   : wdata_q[{beat_q, 4'd0} +: 16];
    assign sram_we = (state_q == WR_BEAT) || (state_q == RMW_WR);
    assign sram_dq = sram_we ? dq_out : 16'hzzzz;

    assign p_ack      = (state_q == RESP) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    assign p_err      = err_q ? p_ack : 2'b00;
    assign p_rdata[0] = p_ack[0] ? rdata_q : 64'd0;
    assign p_rdata[1] = p_ack[1] ? rdata_q : 64'd0;

endmodule
